spi_pwm_slave: RTL and testbench
================================

Name: spi_pwm_slave

Overview:
- SPI-write-only slave that receives one PACK_LENGTH-bit duty-cycle word per chip-select frame and drives a fixed-frequency PWM output with that duty.
- Sits on the SPI bus behind SPI_FPGA_MASTER (shares MOSI/CS/SCLK) and runs on the system clock.
- All SPI inputs are asynchronous to IN_CLOCK_PWM and are oversampled.

Parameters:
- CPHA, 1'b0, SPI clock phase.
- CPOL, 1'b0, SPI clock idle level.
- PACK_LENGTH, 8, bits per frame and width of the duty word.
- PACK_BIT_SEQUENCE_TRANSMIT, 1, kept for interface parity with the master; no transmit path (slave drives no MISO).
- PACK_BIT_SEQUENCE_RECEIVE, 1, 1 = MSB first, 0 = LSB first.
- CLOCK_FREQUENCY, 50000000, IN_CLOCK_PWM frequency in Hz.
- PWM_FREQUENCY, CLOCK_FREQUENCY/32, PWM frequency; PERIOD = CLOCK_FREQUENCY/PWM_FREQUENCY clocks, which must be ≥2.

Ports:
- IN_CLOCK_PWM  in  1  system clock, rising-edge.
- IN_RESET_PWM  in  1  reset; asynchronous, active-low.
- IN_MOSI  in  1  SPI data from master.
- IN_CS  in  1  SPI chip select, active-low.
- IN_SCLK  in  1  SPI clock; ≤ CLOCK_FREQUENCY/8.
- OUT_PWM_SIGNAL  out  1  PWM output.

Behaviour:
- Reset (IN_RESET_PWM=0): OUT_PWM_SIGNAL=0, active duty=0, pending duty=0, PWM counter=0, bit counter=0, frame-valid=0, synchronizer flops at idle levels (CS=1, SCLK=CPOL, MOSI=0).
- Synchronizers:
  - IN_CS, IN_SCLK and IN_MOSI each pass through a 2-flop synchronizer; edges are detected on the synchronized value versus its previous sample.
  - Input-to-action latency is 3 clocks.
- Sample edge:
  - Rising SCLK edge when CPOL==CPHA (modes 0 and 3).
  - Falling SCLK edge otherwise (modes 1 and 2).
  - The other edge is ignored.
- Frame start: a CS falling edge clears the bit counter and shift register and sets frame-valid=1.
- Bit sampling:
  - On each sample edge while CS is low and bit counter < PACK_LENGTH, shift in MOSI and increment the counter.
  - MSB-first: shift left, new bit into bit 0.
  - LSB-first: shift right, new bit into the MSB.
- Excess edges: a sample edge arriving when counter == PACK_LENGTH sets frame-valid=0 (overlong frame).
- Frame end: a CS rising edge copies the shift register into pending duty only if frame-valid=1 and counter == PACK_LENGTH. Short, overlong or aborted frames are discarded and pending duty keeps its value.
- PWM counter: counts 0..PERIOD-1 and wraps.
- Duty reload: at counter==PERIOD-1, active duty ← pending duty, so an update takes effect at the next period start and never glitches mid-period.
- Compare threshold:
  - threshold = (active_duty × PERIOD) >> PACK_LENGTH, computed at full width with no overflow.
  - Use width PACK_LENGTH + $clog2(PERIOD) + 1.
- PWM output:
  - OUT_PWM_SIGNAL is registered, high while counter < threshold.
  - Duty 0 gives constant low.
  - Duty 2^PACK_LENGTH−1 gives PERIOD−1 high clocks per period when PERIOD ≤ 2^PACK_LENGTH.
- Simultaneous events: a CS rising edge and a period wrap in the same clock apply the period reload first (old pending value). The new pending value takes effect one period later.
- Reset mid-frame: the frame is lost, the output goes low immediately, and the next complete frame after reset release is accepted.
- CS glitch: a CS high pulse shorter than the synchronizer window is not required to be seen. Any seen CS rising edge ends the frame.

Decomposition:
- Package spi_pwm_pkg:
  - function sample_on_rising(CPOL,CPHA).
  - function pwm_threshold(duty, PERIOD, PACK_LENGTH).
  - localparam helpers for counter widths ($clog2).
- One sub-module, spi_rx_shift: synchronizers, edge detect, bit counter, shift register and frame-valid. It outputs the PACK_LENGTH-bit word and a one-clock word_valid strobe.
- The top holds pending/active duty, the PWM counter and the comparator.

Test Plan:
- Reset, then send 8'd0 in mode 0 at 12.5 MHz master setting (SCLK 6.25 MHz) -> OUT_PWM_SIGNAL stays 0 across ≥4 periods of 32 clocks.
- Send 8'd255 -> from the first full period after CS rises, 31 clocks high and 1 low per 32-clock period.
- Send 8'd128 then 8'd60 back-to-back -> 16-high/16-low, then 7-high/25-low (60×32>>8=7); each switches exactly at a period boundary.
- PACK_BIT_SEQUENCE_RECEIVE=0, master LSB-first, send 8'd15 -> threshold 1 (one high clock per period); swapped bit order on one side gives 8'hF0 -> 30 high.
- Hold a 128 duty, then a frame aborted after 5 SCLK edges and a 9-edge overlong frame -> duty stays 128 (16 high) for both.
- Repeat the 8'd128 case in modes 1, 2, 3 -> 16 high/16 low in each; assert reset mid-frame -> output 0 within 1 clock, and the next full frame of 8'd255 gives 31 high.

Source files
------------

// File: rtl/spi_pwm_pkg.sv
// Shared helpers for the SPI-controlled PWM slave: sample-edge selection,
// counter widths and the duty-to-threshold conversion.
package spi_pwm_pkg;

  // True when data is sampled on the rising SCLK edge (SPI modes 0 and 3).
  function automatic logic sample_on_rising(input logic cpol, input logic cpha);
    return (cpol == cpha);
  endfunction

  // Bits needed for a counter running 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Number of high clocks per period for a given duty word; wide enough to never overflow.
  function automatic longint unsigned pwm_threshold(input longint unsigned duty,
                                                    input longint unsigned period,
                                                    input int unsigned     pack_length);
    return (duty * period) >> pack_length;
  endfunction

endpackage

// File: rtl/spi_rx_shift.sv
// SPI receive front end: synchronizes CS/SCLK/MOSI, detects edges, shifts in
// one frame and strobes word_valid_o when a frame of exactly PACK_LENGTH bits ends.
module spi_rx_shift #(
  parameter logic        CPOL        = 1'b0,
  parameter logic        CPHA        = 1'b0,
  parameter int unsigned PACK_LENGTH = 8,
  parameter logic        MSB_FIRST   = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cs_i,
  input  logic                   sclk_i,
  input  logic                   mosi_i,
  output logic [PACK_LENGTH-1:0] word_o,
  output logic                   word_valid_o
);
  import spi_pwm_pkg::*;

  localparam int unsigned          BitCntW    = $clog2(PACK_LENGTH + 1);
  localparam logic [BitCntW-1:0]   BitMax     = BitCntW'(PACK_LENGTH);
  localparam logic                 SampleRise = sample_on_rising(CPOL, CPHA);

  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  logic [BitCntW-1:0]     cnt_q, cnt_d;
  logic [PACK_LENGTH-1:0] shift_q, shift_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   word_valid_q, word_valid_d;

  logic cs_fall_c, cs_rise_c, sclk_edge_c, sample_c;

  // Two-flop synchronizers plus one history flop for edge detection; idle levels in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      sclk_meta_q <= CPOL;
      sclk_sync_q <= CPOL;
      sclk_prev_q <= CPOL;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      cs_meta_q   <= cs_i;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      sclk_meta_q <= sclk_i;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= mosi_i;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  // Edge detection on synchronized values; only the mode's sample edge matters.
  always_comb begin
    cs_fall_c   = cs_prev_q & ~cs_sync_q;
    cs_rise_c   = ~cs_prev_q & cs_sync_q;
    sclk_edge_c = SampleRise ? (~sclk_prev_q & sclk_sync_q) : (sclk_prev_q & ~sclk_sync_q);
    sample_c    = sclk_edge_c & ~cs_sync_q;
  end

  // Frame tracking: start clears, sample edges shift, end qualifies the word.
  always_comb begin
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    frame_valid_d = frame_valid_q;
    word_valid_d  = 1'b0;
    if (cs_fall_c) begin
      cnt_d         = '0;
      shift_d       = '0;
      frame_valid_d = 1'b1;
    end else if (cs_rise_c) begin
      word_valid_d  = frame_valid_q && (cnt_q == BitMax);
      frame_valid_d = 1'b0;
    end else if (sample_c) begin
      if (cnt_q < BitMax) begin
        if (MSB_FIRST) begin
          shift_d = {shift_q[PACK_LENGTH-2:0], mosi_sync_q};
        end else begin
          shift_d = {mosi_sync_q, shift_q[PACK_LENGTH-1:1]};
        end
        cnt_d = cnt_q + BitCntW'(1);
      end else begin
        frame_valid_d = 1'b0;
      end
    end
  end

  // Frame state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q         <= '0;
      shift_q       <= '0;
      frame_valid_q <= 1'b0;
      word_valid_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      frame_valid_q <= frame_valid_d;
      word_valid_q  <= word_valid_d;
    end
  end

  assign word_o       = shift_q;
  assign word_valid_o = word_valid_q;

endmodule

// File: rtl/spi_pwm_slave.sv
// SPI write-only slave: each accepted frame sets the PWM duty, which is
// applied at the next period start so the output never glitches mid-period.
module spi_pwm_slave #(
  parameter logic        CPOL                       = 1'b0,
  parameter logic        CPHA                       = 1'b0,
  parameter int unsigned PACK_LENGTH                = 8,
  parameter int unsigned PACK_BIT_SEQUENCE_TRANSMIT = 1,
  parameter int unsigned PACK_BIT_SEQUENCE_RECEIVE  = 1,
  parameter int unsigned CLOCK_FREQUENCY            = 50000000,
  parameter int unsigned PWM_FREQUENCY              = CLOCK_FREQUENCY / 32
) (
  input  logic IN_CLOCK_PWM,
  input  logic IN_RESET_PWM,
  input  logic IN_MOSI,
  input  logic IN_CS,
  input  logic IN_SCLK,
  output logic OUT_PWM_SIGNAL
);
  import spi_pwm_pkg::*;

  localparam int unsigned       Period = CLOCK_FREQUENCY / PWM_FREQUENCY;
  localparam int unsigned       CntW   = cnt_width(Period);
  localparam int unsigned       ThrW   = PACK_LENGTH + $clog2(Period) + 1;
  localparam logic [CntW-1:0]   CntMax = CntW'(Period - 1);

  logic [PACK_LENGTH-1:0] rx_word;
  logic                   rx_valid;

  logic [PACK_LENGTH-1:0] pending_q, pending_d;
  logic [PACK_LENGTH-1:0] active_q, active_d;
  logic [CntW-1:0]        pwm_cnt_q, pwm_cnt_d;
  logic                   pwm_q, pwm_d;
  logic [ThrW-1:0]        thr_d;

  // The slave never drives MISO, so the transmit bit order has no effect here.
  if (PACK_BIT_SEQUENCE_TRANSMIT != 0) begin : g_tx_order_unused
  end

  spi_rx_shift #(
    .CPOL        (CPOL),
    .CPHA        (CPHA),
    .PACK_LENGTH (PACK_LENGTH),
    .MSB_FIRST   (PACK_BIT_SEQUENCE_RECEIVE != 0)
  ) u_rx (
    .clk_i        (IN_CLOCK_PWM),
    .rst_ni       (IN_RESET_PWM),
    .cs_i         (IN_CS),
    .sclk_i       (IN_SCLK),
    .mosi_i       (IN_MOSI),
    .word_o       (rx_word),
    .word_valid_o (rx_valid)
  );

  // Period counter, duty reload at wrap (old pending wins a same-cycle update), comparator.
  always_comb begin
    pending_d = rx_valid ? rx_word : pending_q;
    if (pwm_cnt_q == CntMax) begin
      pwm_cnt_d = '0;
      active_d  = pending_q;
    end else begin
      pwm_cnt_d = pwm_cnt_q + CntW'(1);
      active_d  = active_q;
    end
    thr_d = ThrW'(pwm_threshold(64'(active_d), 64'(Period), PACK_LENGTH));
    pwm_d = (ThrW'(pwm_cnt_d) < thr_d);
  end

  // Duty, counter and output registers; output is aligned with the counter value.
  always_ff @(posedge IN_CLOCK_PWM or negedge IN_RESET_PWM) begin
    if (!IN_RESET_PWM) begin
      pending_q <= '0;
      active_q  <= '0;
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      active_q  <= active_d;
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_d;
    end
  end

  assign OUT_PWM_SIGNAL = pwm_q;

endmodule

// File: tb/tb_spi_pwm_slave.sv
// Bench for spi_pwm_slave: five instances (modes 0..3 MSB-first, mode 0 LSB-first)
// on a shared MOSI with private CS/SCLK; high/low run lengths are checked per period.
module tb_spi_pwm_slave;

  localparam int HalfSclk = 80;  // 6.25 MHz SCLK against a 50 MHz system clock

  typedef struct {
    int          inst;
    logic [7:0]  data;
    int          nbits;
    bit          lsb;
    int          hi;
    int          lo;
    string       name;
  } vec_t;

  typedef struct {
    int    hi;
    int    lo;
    string name;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       mosi;
  logic [4:0] cs;
  logic [4:0] sclk;
  logic [4:0] pwm;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];
  exp_t sb_q[$];

  initial clk = 1'b0;
  always #10 clk = ~clk;

  spi_pwm_slave #(.CPOL(1'b0), .CPHA(1'b0)) u_m0 (
    .IN_CLOCK_PWM(clk), .IN_RESET_PWM(rst_n), .IN_MOSI(mosi),
    .IN_CS(cs[0]), .IN_SCLK(sclk[0]), .OUT_PWM_SIGNAL(pwm[0]));
  spi_pwm_slave #(.CPOL(1'b0), .CPHA(1'b1)) u_m1 (
    .IN_CLOCK_PWM(clk), .IN_RESET_PWM(rst_n), .IN_MOSI(mosi),
    .IN_CS(cs[1]), .IN_SCLK(sclk[1]), .OUT_PWM_SIGNAL(pwm[1]));
  spi_pwm_slave #(.CPOL(1'b1), .CPHA(1'b0)) u_m2 (
    .IN_CLOCK_PWM(clk), .IN_RESET_PWM(rst_n), .IN_MOSI(mosi),
    .IN_CS(cs[2]), .IN_SCLK(sclk[2]), .OUT_PWM_SIGNAL(pwm[2]));
  spi_pwm_slave #(.CPOL(1'b1), .CPHA(1'b1)) u_m3 (
    .IN_CLOCK_PWM(clk), .IN_RESET_PWM(rst_n), .IN_MOSI(mosi),
    .IN_CS(cs[3]), .IN_SCLK(sclk[3]), .OUT_PWM_SIGNAL(pwm[3]));
  spi_pwm_slave #(.CPOL(1'b0), .CPHA(1'b0), .PACK_BIT_SEQUENCE_RECEIVE(0)) u_lsb (
    .IN_CLOCK_PWM(clk), .IN_RESET_PWM(rst_n), .IN_MOSI(mosi),
    .IN_CS(cs[4]), .IN_SCLK(sclk[4]), .OUT_PWM_SIGNAL(pwm[4]));

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add_vec(input int inst, input logic [7:0] data, input int nbits, input bit lsb,
                         input int hi, input int lo, input string name);
    vec_t v;
    v.inst = inst; v.data = data; v.nbits = nbits; v.lsb = lsb;
    v.hi = hi; v.lo = lo; v.name = name;
    vecs.push_back(v);
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int i, input bit lsb);
    int j;
    j = i % 8;
    return lsb ? d[j] : d[7-j];
  endfunction

  // SPI master for instance k: nbits sample edges in that instance's mode.
  task automatic send(input int k, input logic [7:0] data, input int nbits, input bit lsb);
    logic cpol, cpha;
    cpol = (k == 2 || k == 3);
    cpha = (k == 1 || k == 3);
    @(negedge clk);
    sclk[k] = cpol;
    cs[k]   = 1'b0;
    if (!cpha) mosi = frame_bit(data, 0, lsb);
    #HalfSclk;
    for (int i = 0; i < nbits; i++) begin
      if (cpha) mosi = frame_bit(data, i, lsb);
      sclk[k] = ~cpol;
      #HalfSclk;
      sclk[k] = cpol;
      if (!cpha && (i + 1 < nbits)) mosi = frame_bit(data, i + 1, lsb);
      #HalfSclk;
    end
    cs[k] = 1'b1;
    #(2 * HalfSclk);
  endtask

  task automatic wait_rise(input int k, output bit ok);
    logic prev;
    ok   = 1'b0;
    prev = pwm[k];
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!prev && pwm[k]) begin
        ok = 1'b1;
        break;
      end
      prev = pwm[k];
    end
  endtask

  // Starting on a high sample, count the high run then the following low run.
  task automatic run_pair(input int k, output int hi, output int lo);
    hi = 0;
    while (pwm[k] && hi < 200) begin
      hi++;
      @(negedge clk);
    end
    lo = 0;
    while (!pwm[k] && lo < 200) begin
      lo++;
      @(negedge clk);
    end
  endtask

  task automatic count_high(input int k, input int clocks, output int highs);
    highs = 0;
    for (int n = 0; n < clocks; n++) begin
      @(negedge clk);
      if (pwm[k]) highs++;
    end
  endtask

  // Pop the next expected duty shape and compare against the measured waveform.
  task automatic check_duty(input int k);
    exp_t e;
    bit   ok;
    int   hi, lo;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = sb_q.pop_front();
    if (e.hi == 0) begin
      count_high(k, 4 * 32, hi);
      chk({e.name, "_const_low"}, hi, 0);
    end else begin
      wait_rise(k, ok);
      chk({e.name, "_rise_seen"}, int'(ok), 1);
      if (ok) begin
        run_pair(k, hi, lo);
        chk({e.name, "_high"}, hi, e.hi);
        chk({e.name, "_low"}, lo, e.lo);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    bit   seen_new;
    int   hi, lo;
    exp_t e;

    rst_n = 1'b0;
    mosi  = 1'b0;
    cs    = 5'h1F;
    sclk  = 5'b01100;

    add_vec(0, 8'd0,   8, 1'b0, 0,  32, "m0_zero");
    add_vec(0, 8'd255, 8, 1'b0, 31, 1,  "m0_full");
    add_vec(0, 8'd128, 8, 1'b0, 16, 16, "m0_half");
    add_vec(0, 8'h1F,  5, 1'b0, 16, 16, "m0_abort5");
    add_vec(0, 8'hAA,  9, 1'b0, 16, 16, "m0_overlong9");
    add_vec(1, 8'd128, 8, 1'b0, 16, 16, "m1_half");
    add_vec(2, 8'd128, 8, 1'b0, 16, 16, "m2_half");
    add_vec(3, 8'd128, 8, 1'b0, 16, 16, "m3_half");
    add_vec(4, 8'd15,  8, 1'b1, 1,  31, "lsb_15");
    add_vec(4, 8'd15,  8, 1'b0, 30, 2,  "lsb_swapped_f0");

    repeat (3) @(negedge clk);
    chk("reset_pwm_low", int'(pwm), 0);
    rst_n = 1'b1;
    count_high(0, 64, hi);
    chk("idle_after_reset", hi, 0);

    foreach (vecs[i]) begin
      send(vecs[i].inst, vecs[i].data, vecs[i].nbits, vecs[i].lsb);
      e.hi = vecs[i].hi; e.lo = vecs[i].lo; e.name = vecs[i].name;
      sb_q.push_back(e);
      repeat (40) @(negedge clk);
      check_duty(vecs[i].inst);
    end

    // Back-to-back 128 then 60: every period is either 16/16 or 7/25, switching once.
    send(0, 8'd128, 8, 1'b0);
    send(0, 8'd60, 8, 1'b0);
    wait_rise(0, ok);
    chk("b2b_rise_seen", int'(ok), 1);
    if (ok) begin
      seen_new = 1'b0;
      for (int p = 0; p < 5; p++) begin
        run_pair(0, hi, lo);
        if (seen_new || hi == 7) begin
          seen_new = 1'b1;
          chk($sformatf("b2b_new%0d_high", p), hi, 7);
          chk($sformatf("b2b_new%0d_low", p), lo, 25);
        end else begin
          chk($sformatf("b2b_old%0d_high", p), hi, 16);
          chk($sformatf("b2b_old%0d_low", p), lo, 16);
        end
      end
      chk("b2b_switched", int'(seen_new), 1);
    end

    // Reset in the middle of a frame while the output is high.
    @(negedge clk);
    cs[0] = 1'b0;
    mosi  = 1'b1;
    #HalfSclk;
    for (int i = 0; i < 3; i++) begin
      sclk[0] = 1'b1;
      #HalfSclk;
      sclk[0] = 1'b0;
      #HalfSclk;
    end
    ok = 1'b0;
    for (int n = 0; n < 80 && !ok; n++) begin
      @(negedge clk);
      if (pwm[0]) ok = 1'b1;
    end
    chk("midrst_pre_high", int'(ok), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_async_low", int'(pwm[0]), 0);
    repeat (3) @(negedge clk);
    chk("midrst_hold_low", int'(pwm[0]), 0);
    cs[0]   = 1'b1;
    sclk[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_high(0, 64, hi);
    chk("midrst_duty_cleared", hi, 0);
    send(0, 8'd255, 8, 1'b0);
    e.hi = 31; e.lo = 1; e.name = "midrst_next_full";
    sb_q.push_back(e);
    repeat (40) @(negedge clk);
    check_duty(0);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
